sigma_delta_dac_2nd: RTL and testbench



---
 rtl/sigma_delta_dac_2nd.sv | 113 +++++++++++
 tb/tb_sigma_delta_dac_2nd.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sigma_delta_dac_2nd.sv
// sigma_delta_dac_2nd
//   Second-order single-bit delta-sigma modulator. It turns a 20-bit unsigned
//   PCM sample into a PDM bit stream whose ones density tracks the sample
//   level. The output drives an RC-filtered audio pin.
//
// Ports
//   clk      DAC clock; all state changes on its rising edge
//   reset    synchronous, active-high; clears both integrators and dac_out
//   clk_ena  modulator step enable; state holds while low
//   pcm_in   offset-binary sample, mid-scale = 2^(IN_W-2), MSB unused (0)
//   dac_out  registered modulator bit
module sigma_delta_dac_2nd #(
  parameter int IN_W = 20,
  parameter int I1_W = 24,
  parameter int I2_W = 28
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clk_ena,
  input  logic [IN_W-1:0] pcm_in,
  output logic            dac_out
);

  // Working widths: two guard bits above the widest operand, so the
  // unclamped sums can never wrap before they are saturated.
  localparam int XS_W  = IN_W + 1;
  localparam int MAX1  = (I1_W > XS_W) ? I1_W : XS_W;
  localparam int S1_W  = MAX1 + 2;
  localparam int MAX2A = (I2_W > I1_W) ? I2_W : I1_W;
  localparam int MAX2  = (MAX2A > XS_W) ? MAX2A : XS_W;
  localparam int S2_W  = MAX2 + 2;

  // Half of the usable input range; also the feedback magnitude.
  localparam logic signed [XS_W-1:0] H =
    {2'b00, 1'b1, {(IN_W-2){1'b0}}};

  // Saturation limits of each integrator, expressed at the working width.
  localparam logic signed [S1_W-1:0] I1_MAX =
    {{(S1_W-I1_W+1){1'b0}}, {(I1_W-1){1'b1}}};
  localparam logic signed [S1_W-1:0] I1_MIN =
    {{(S1_W-I1_W+1){1'b1}}, {(I1_W-1){1'b0}}};
  localparam logic signed [S2_W-1:0] I2_MAX =
    {{(S2_W-I2_W+1){1'b0}}, {(I2_W-1){1'b1}}};
  localparam logic signed [S2_W-1:0] I2_MIN =
    {{(S2_W-I2_W+1){1'b1}}, {(I2_W-1){1'b0}}};

  logic signed [I1_W-1:0] i1_q, i1_d, i1_step;
  logic signed [I2_W-1:0] i2_q, i2_d, i2_step;
  logic                   dac_q, dac_d, dac_step;

  logic signed [XS_W-1:0] xs;
  logic signed [XS_W-1:0] fbs;
  logic signed [S1_W-1:0] sum1, sat1;
  logic signed [S2_W-1:0] sum2, sat2;

  // One modulator step, computed every cycle and committed only when enabled.
  always_comb begin
    xs  = $signed({1'b0, pcm_in}) - H;
    fbs = dac_q ? H : -H;

    sum1 = {{(S1_W-I1_W){i1_q[I1_W-1]}}, i1_q}
         + {{(S1_W-XS_W){xs[XS_W-1]}}, xs}
         - {{(S1_W-XS_W){fbs[XS_W-1]}}, fbs};
    if (sum1 > I1_MAX) begin
      sat1 = I1_MAX;
    end else if (sum1 < I1_MIN) begin
      sat1 = I1_MIN;
    end else begin
      sat1 = sum1;
    end
    i1_step = sat1[I1_W-1:0];

    // The second integrator accumulates the freshly updated first integrator.
    sum2 = {{(S2_W-I2_W){i2_q[I2_W-1]}}, i2_q}
         + {{(S2_W-I1_W){i1_step[I1_W-1]}}, i1_step}
         - {{(S2_W-XS_W){fbs[XS_W-1]}}, fbs};
    if (sum2 > I2_MAX) begin
      sat2 = I2_MAX;
    end else if (sum2 < I2_MIN) begin
      sat2 = I2_MIN;
    end else begin
      sat2 = sum2;
    end
    i2_step  = sat2[I2_W-1:0];
    dac_step = ~sat2[S2_W-1];
  end

  always_comb begin
    i1_d  = i1_q;
    i2_d  = i2_q;
    dac_d = dac_q;
    if (clk_ena) begin
      i1_d  = i1_step;
      i2_d  = i2_step;
      dac_d = dac_step;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i1_q  <= '0;
      i2_q  <= '0;
      dac_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      dac_q <= dac_d;
    end
  end

  assign dac_out = dac_q;

endmodule

// File: tb/tb_sigma_delta_dac_2nd.sv
module tb_sigma_delta_dac_2nd;

  localparam longint H      = 64'sd262144;       // 2^18
  localparam longint I1_LIM = 64'sd8388608;      // 2^23
  localparam longint I2_LIM = 64'sd134217728;    // 2^27

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_ena = 1'b0;
  logic [19:0] pcm_in = '0;
  logic        dac_out;

  int unsigned checks = 0;
  int unsigned failures = 0;
  bit          chk_en = 1'b0;

  // Reference state, kept as plain integers.
  longint m_i1 = 0;
  longint m_i2 = 0;
  bit     m_dac = 1'b0;

  sigma_delta_dac_2nd #(.IN_W(20), .I1_W(24), .I2_W(28)) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_ena (clk_ena),
    .pcm_in  (pcm_in),
    .dac_out (dac_out)
  );

  always #5 clk = ~clk;

  function automatic longint clamp(input longint v, input longint lim);
    if (v > lim - 1) return lim - 1;
    if (v < -lim)    return -lim;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input longint act,
                         input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  // Reference model: one modulator step straight from the arithmetic rules.
  always @(posedge clk) begin
    longint xs, fb, n1, n2;
    if (reset) begin
      m_i1  <= 0;
      m_i2  <= 0;
      m_dac <= 1'b0;
    end else if (clk_ena) begin
      xs = longint'(pcm_in) - H;
      fb = m_dac ? H : -H;
      n1 = clamp(m_i1 + xs - fb, I1_LIM);
      n2 = clamp(m_i2 + n1 - fb, I2_LIM);
      m_i1  <= n1;
      m_i2  <= n2;
      m_dac <= (n2 >= 0);
    end
  end

  // Every cycle, away from the active edge, the DUT must match the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_dac", longint'(dac_out), longint'(m_dac));
      chk("cyc_i1", longint'(dut.i1_q), m_i1);
      chk("cyc_i2", longint'(dut.i2_q), m_i2);
    end
  end

  task automatic tick(input bit r, input bit e, input logic [19:0] p);
    @(negedge clk);
    reset   = r;
    clk_ena = e;
    pcm_in  = p;
    @(posedge clk);
    #1;
  endtask

  // Enabled steps at a fixed level; returns the ones count over the last n.
  task automatic run_density(input logic [19:0] p, input int unsigned settle,
                             input int unsigned n, input int unsigned gap,
                             output int unsigned ones);
    bit prev;
    ones = 0;
    for (int unsigned k = 0; k < settle; k++) tick(1'b0, 1'b1, p);
    for (int unsigned k = 0; k < n; k++) begin
      tick(1'b0, 1'b1, p);
      if (dac_out) ones++;
      prev = dac_out;
      for (int unsigned g = 0; g < gap; g++) begin
        tick(1'b0, 1'b0, p);
        if (dac_out != prev) chk("hold_between_enables", longint'(dac_out), longint'(prev));
      end
    end
  endtask

  initial begin
    int unsigned ones;
    bit          s_dac;
    longint      s_i1, s_i2;

    // Reset held with enable active and a full-scale input.
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b1, 20'h7FFFF);
      chk_en = 1'b1;
      chk("reset_dac", longint'(dac_out), 0);
    end
    tick(1'b0, 1'b0, 20'h7FFFF);
    chk("post_release_dac", longint'(dac_out), 0);
    chk("post_release_i1", longint'(dut.i1_q), 0);

    // First two steps from reset at mid-scale, hand-computed.
    tick(1'b1, 1'b0, 20'h40000);
    tick(1'b0, 1'b1, 20'h40000);
    chk("step1_model_i1", m_i1, 64'h40000);
    chk("step1_model_i2", m_i2, 64'h80000);
    chk("step1_i1", longint'(dut.i1_q), 64'h40000);
    chk("step1_i2", longint'(dut.i2_q), 64'h80000);
    chk("step1_dac", longint'(dac_out), 1);
    tick(1'b0, 1'b1, 20'h40000);
    chk("step2_model_i1", m_i1, 0);
    chk("step2_i1", longint'(dut.i1_q), 0);
    chk("step2_i2", longint'(dut.i2_q), 64'h40000);
    chk("step2_dac", longint'(dac_out), 1);

    // Mid-scale, enable every 4th clock.
    run_density(20'h40000, 0, 8192, 3, ones);
    chk_rng("density_mid", ones, 4096 - 41, 4096 + 41);

    // Quarter and three-quarter scale.
    run_density(20'h20000, 64, 8192, 0, ones);
    chk_rng("density_quarter", ones, 2048 - 41, 2048 + 41);
    run_density(20'h60000, 64, 8192, 0, ones);
    chk_rng("density_3quarter", ones, 6144 - 41, 6144 + 41);

    // Pinned at zero input: integrators must stay inside their bounds.
    for (int unsigned k = 0; k < 10000; k++) begin
      tick(1'b0, 1'b1, 20'h00000);
      if (k % 1000 == 999) begin
        chk_rng("sat_i1_bound", longint'(dut.i1_q), -I1_LIM, I1_LIM - 1);
        chk_rng("sat_i2_bound", longint'(dut.i2_q), -I2_LIM, I2_LIM - 1);
      end
    end
    // Back to mid-scale: 64 recovery steps, then density must be ~50%.
    run_density(20'h40000, 64, 4096, 0, ones);
    chk_rng("density_recovery", ones, 2048 - 82, 2048 + 82);

    // Enable gating with a changing input.
    s_dac = dac_out;
    s_i1  = longint'(dut.i1_q);
    s_i2  = longint'(dut.i2_q);
    for (int unsigned k = 0; k < 100; k++) tick(1'b0, 1'b0, 20'($urandom_range(0, 20'h7FFFF)));
    chk("gate_dac", longint'(dac_out), longint'(s_dac));
    chk("gate_i1", longint'(dut.i1_q), s_i1);
    chk("gate_i2", longint'(dut.i2_q), s_i2);
    tick(1'b0, 1'b1, 20'h30000);

    // Reset mid-stream.
    tick(1'b1, 1'b1, 20'h50000);
    chk("midreset_dac", longint'(dac_out), 0);
    chk("midreset_i2", longint'(dut.i2_q), 0);
    tick(1'b0, 1'b0, 20'h50000);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
